// File: rtl/engine_configure_memory_request_sequencer_if.sv
// Request/response bus between the configuration sequencer and the memory request arbiter.
// Each accepted request is answered later by exactly one resp_valid_in pulse.
interface engine_configure_memory_request_sequencer_if #(
   parameter int ADDR_WIDTH = 64
);
   logic                  req_valid_out;
   logic                  req_ready_in;
   logic [ADDR_WIDTH-1:0] req_address_out;
   logic [15:0]           req_offset_out;
   logic                  resp_valid_in;

   modport master (
      output req_valid_out, req_address_out, req_offset_out,
      input  req_ready_in, resp_valid_in
   );

   modport slave (
      input  req_valid_out, req_address_out, req_offset_out,
      output req_ready_in, resp_valid_in
   );
endinterface

// File: rtl/engine_configure_memory_request_sequencer.sv
// Issues one credit-throttled read per configuration word of every engine in a lane,
// counts the returned words and pulses done once all of them are back.
module engine_configure_memory_request_sequencer #(
   parameter int NUM_ENGINES      = 4,
   parameter int ENGINE_SEQ_WIDTH = 16,
   parameter int WORD_BYTES       = 4,
   parameter int ADDR_WIDTH       = 64,
   parameter int MAX_OUTSTANDING  = 8
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  start_in,
   input  logic [ADDR_WIDTH-1:0] cfg_base_address_in,
   engine_configure_memory_request_sequencer_if.master mem,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  stray_resp_out
);
   localparam int TOTAL_WORDS = NUM_ENGINES * ENGINE_SEQ_WIDTH;
   localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [15:0]      TOTAL_W  = 16'(TOTAL_WORDS);
   localparam logic [15:0]      LAST_W   = 16'(TOTAL_WORDS - 1);
   localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [15:0]           issue_cnt_q, issue_cnt_d;
   logic [15:0]           resp_cnt_q, resp_cnt_d;
   logic [OUT_W-1:0]      outstanding_q, outstanding_d;
   logic                  valid_q, valid_d;
   logic                  stray_q, stray_d;
   logic                  hs, resp_ok;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q       <= IDLE;
         base_q        <= '0;
         issue_cnt_q   <= '0;
         resp_cnt_q    <= '0;
         outstanding_q <= '0;
         valid_q       <= 1'b0;
         stray_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         issue_cnt_q   <= issue_cnt_d;
         resp_cnt_q    <= resp_cnt_d;
         outstanding_q <= outstanding_d;
         valid_q       <= valid_d;
         stray_q       <= stray_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      issue_cnt_d   = issue_cnt_q;
      resp_cnt_d    = resp_cnt_q;
      outstanding_d = outstanding_q;
      valid_d       = valid_q;
      stray_d       = stray_q;

      hs      = valid_q & mem.req_ready_in;
      // A response only counts against a read we actually have in flight.
      resp_ok = mem.resp_valid_in && (outstanding_q != '0) && (state_q != IDLE);
      if (mem.resp_valid_in && !resp_ok) stray_d = 1'b1;

      if (hs)      issue_cnt_d = issue_cnt_q + 16'd1;
      if (resp_ok) resp_cnt_d  = resp_cnt_q + 16'd1;
      if (hs && !resp_ok)      outstanding_d = outstanding_q + OUT_W'(1);
      else if (!hs && resp_ok) outstanding_d = outstanding_q - OUT_W'(1);

      case (state_q)
         IDLE: begin
            if (start_in) begin
               state_d       = ISSUE;
               base_d        = cfg_base_address_in;
               issue_cnt_d   = '0;
               resp_cnt_d    = '0;
               outstanding_d = '0;
               stray_d       = 1'b0;
               valid_d       = 1'b1;
            end
         end
         ISSUE: begin
            if (hs && issue_cnt_q == LAST_W) begin
               valid_d = 1'b0;
               state_d = (resp_cnt_d == TOTAL_W) ? DONE : DRAIN;
            end else if (!(valid_q && !mem.req_ready_in)) begin
               // Credit is judged against next-cycle occupancy; a pending request is never withdrawn.
               valid_d = (outstanding_d < MAX_OUT);
            end
         end
         DRAIN: begin
            if (resp_cnt_d == TOTAL_W) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem.req_valid_out   = valid_q;
   assign mem.req_offset_out  = issue_cnt_q;
   assign mem.req_address_out = base_q + ADDR_WIDTH'(issue_cnt_q) * ADDR_WIDTH'(WORD_BYTES);
   assign busy_out            = (state_q != IDLE);
   assign done_out            = (state_q == DONE);
   assign stray_resp_out      = stray_q;
endmodule

// File: tb/tb_engine_configure_memory_request_sequencer.sv
// Randomized bench for the configuration request sequencer: a phase/credit model predicts
// every cycle, and a scoreboard checks the handshake stream of each run.
module tb_engine_configure_memory_request_sequencer;
   localparam int NE    = 2;
   localparam int ESW   = 16;
   localparam int TOTAL = NE * ESW;
   localparam int MAXO  = 8;
   localparam int AW    = 64;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic          start_in = 1'b0;
   logic [AW-1:0] cfg_base = '0;
   logic          busy_out, done_out, stray_resp_out;

   engine_configure_memory_request_sequencer_if #(.ADDR_WIDTH(AW)) mif ();

   engine_configure_memory_request_sequencer #(
      .NUM_ENGINES(NE), .ENGINE_SEQ_WIDTH(ESW), .WORD_BYTES(4),
      .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start_in(start_in),
      .cfg_base_address_in(cfg_base), .mem(mif.master),
      .busy_out(busy_out), .done_out(done_out), .stray_resp_out(stray_resp_out)
   );

   always #5 ap_clk = ~ap_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // stimulus controls
   int        cyc = 0;
   int        rdy_mode = 0;    // 0 always ready, 1 random, 2 stall on offset 3
   int        resp_mode = 0;   // 0 fixed delay, 1 random delay, 2 withheld
   int        resp_delay = 3;
   int        stall_left = 0;
   bit        resp_one = 0;
   bit        resp_force = 0;
   int        due[$];

   // scoreboard
   int        sb_next = 0;
   int        hs_cnt = 0;
   int        done_cnt = 0;
   logic [AW-1:0] run_base = '0;

   // behavioural model
   int            m_ph;       // 0 idle, 1 issue, 2 drain, 3 done
   bit            m_v, m_st;
   int            m_iss, m_rsp, m_out;
   logic [AW-1:0] m_base;

   initial begin
      mif.req_ready_in  = 1'b1;
      mif.resp_valid_in = 1'b0;
      forever begin
         @(posedge ap_clk);
         #1;
         cyc++;
         case (rdy_mode)
            0: mif.req_ready_in = 1'b1;
            1: mif.req_ready_in = ($urandom_range(0, 3) != 0);
            default: begin
               if (mif.req_valid_out && mif.req_offset_out == 16'd3 && stall_left > 0) begin
                  mif.req_ready_in = 1'b0;
                  stall_left--;
               end else mif.req_ready_in = 1'b1;
            end
         endcase
         mif.resp_valid_in = 1'b0;
         if (resp_force) begin
            mif.resp_valid_in = 1'b1;
            resp_force = 0;
         end else if (resp_one) begin
            mif.resp_valid_in = 1'b1;
            resp_one = 0;
            if (due.size() > 0) void'(due.pop_front());
         end else if (resp_mode != 2 && due.size() > 0 && due[0] <= cyc) begin
            mif.resp_valid_in = 1'b1;
            void'(due.pop_front());
         end
      end
   end

   always @(posedge ap_clk or negedge ap_rst_n) begin : mdl
      int iss, rsp, outs, ph;
      bit hs, rok, v, st;
      if (!ap_rst_n) begin
         m_ph <= 0; m_v <= 0; m_st <= 0;
         m_iss <= 0; m_rsp <= 0; m_out <= 0; m_base <= '0;
      end else begin
         hs   = m_v && mif.req_ready_in;
         rok  = mif.resp_valid_in && m_out > 0 && m_ph != 0;
         iss  = m_iss + int'(hs);
         rsp  = m_rsp + int'(rok);
         outs = m_out + int'(hs) - int'(rok);
         st   = m_st || (mif.resp_valid_in && !rok);
         ph   = m_ph;
         v    = m_v;
         case (m_ph)
            0: if (start_in) begin
               m_base <= cfg_base;
               iss = 0; rsp = 0; outs = 0; st = 0; ph = 1; v = 1;
            end
            1: if (hs && iss == TOTAL) begin
               v  = 0;
               ph = (rsp == TOTAL) ? 3 : 2;
            end else v = (m_v && !mif.req_ready_in) || outs < MAXO;
            2: if (rsp == TOTAL) ph = 3;
            default: ph = 0;
         endcase
         m_ph <= ph; m_v <= v; m_st <= st;
         m_iss <= iss; m_rsp <= rsp; m_out <= outs;
      end
   end

   initial begin
      forever begin
         @(negedge ap_clk);
         chk("valid", mif.req_valid_out, m_v);
         chk("busy", busy_out, m_ph != 0);
         chk("done", done_out, m_ph == 3);
         chk("stray", stray_resp_out, m_st);
         if (m_v) begin
            chk("offset", mif.req_offset_out, 64'(m_iss));
            chk("address", mif.req_address_out, m_base + 64'(m_iss) * 64'd4);
         end
         if (ap_rst_n && mif.req_valid_out && mif.req_ready_in) begin
            chk("hs_offset", mif.req_offset_out, 64'(sb_next));
            chk("hs_address", mif.req_address_out, run_base + 64'(sb_next) * 64'd4);
            sb_next++;
            hs_cnt++;
            due.push_back(cyc + 1 + (resp_mode == 1 ? int'($urandom_range(1, 6)) : resp_delay));
         end
         if (done_out) done_cnt++;
      end
   end

   task automatic run_start(input logic [AW-1:0] base);
      sb_next  = 0;
      hs_cnt   = 0;
      done_cnt = 0;
      run_base = base;
      due.delete();
      @(posedge ap_clk); #1;
      cfg_base = base;
      start_in = 1'b1;
      @(posedge ap_clk); #1;
      start_in = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int t = 0;
      while (done_cnt == 0 && t < 2000) begin
         @(negedge ap_clk);
         t++;
      end
      chk({tag, "_done_seen"}, done_cnt != 0, 1'b1);
      repeat (4) @(negedge ap_clk);
      chk({tag, "_handshakes"}, 64'(hs_cnt), 64'(TOTAL));
      chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, "_busy_low"}, busy_out, 1'b0);
   endtask

   initial begin
      int t;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("rst_valid", mif.req_valid_out, 1'b0);
      chk("rst_addr", mif.req_address_out, 64'd0);
      chk("rst_busy", busy_out, 1'b0);
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;

      // response while idle
      resp_force = 1;
      repeat (3) @(negedge ap_clk);
      chk("idle_stray_set", stray_resp_out, 1'b1);
      chk("idle_no_req", mif.req_valid_out, 1'b0);

      // basic run with an ignored start mid-issue
      resp_mode = 0; resp_delay = 3;
      run_start(64'h1000);
      @(negedge ap_clk);
      chk("start_clears_stray", stray_resp_out, 1'b0);
      chk("first_valid", mif.req_valid_out, 1'b1);
      repeat (6) @(posedge ap_clk);
      #1;
      cfg_base = 64'hDEAD_0000;
      start_in = 1'b1;
      @(posedge ap_clk); #1;
      start_in = 1'b0;
      wait_done("basic");

      // credit limit with responses withheld
      resp_mode = 2;
      run_start(64'h2000);
      repeat (20) @(negedge ap_clk);
      chk("credit_hs", 64'(hs_cnt), 64'd8);
      chk("credit_valid_low", mif.req_valid_out, 1'b0);
      resp_one = 1;
      @(negedge ap_clk);
      chk("credit_same_cycle", mif.req_valid_out, 1'b0);
      @(negedge ap_clk);
      chk("credit_reopen", mif.req_valid_out, 1'b1);
      chk("credit_offset8", mif.req_offset_out, 64'd8);
      resp_mode = 1; rdy_mode = 1;
      wait_done("credit");

      // backpressure on offset 3, then steady delay-4 traffic
      rdy_mode = 2; stall_left = 5; resp_mode = 0; resp_delay = 4;
      run_start(64'h3000);
      t = 0;
      while (mif.req_ready_in !== 1'b0 && t < 200) begin
         @(negedge ap_clk);
         t++;
      end
      chk("stall_seen", mif.req_ready_in, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", mif.req_valid_out, 1'b1);
         chk("stall_offset", mif.req_offset_out, 64'd3);
         chk("stall_addr", mif.req_address_out, 64'h300C);
         @(negedge ap_clk);
      end
      wait_done("stall");

      // random traffic, then reset in mid-run
      rdy_mode = 1; resp_mode = 1;
      run_start(64'hFFFF_FFFF_FFFF_FFC0);
      wait_done("wrap");
      rdy_mode = 0;
      run_start(64'h4000);
      t = 0;
      while (hs_cnt < 10 && t < 500) begin
         @(negedge ap_clk);
         t++;
      end
      @(posedge ap_clk); #3;
      ap_rst_n = 1'b0;
      #1;
      chk("arst_valid", mif.req_valid_out, 1'b0);
      chk("arst_busy", busy_out, 1'b0);
      chk("arst_addr", mif.req_address_out, 64'd0);
      chk("arst_offset", mif.req_offset_out, 64'd0);
      due.delete();
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      resp_mode = 0; resp_delay = 2;
      run_start(64'h5000);
      @(negedge ap_clk);
      chk("restart_offset0", mif.req_offset_out, 64'd0);
      wait_done("restart");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/engine_configure_memory_request_sequencer.md
Name: engine_configure_memory_request_sequencer

Overview:
- Fetches the configuration words for every engine in a lane from configuration memory.
- On start, issues one read request per configuration word, tagged with a flat offset 0..TOTAL_WORDS-1. Each engine's configure-memory block filters responses by its offset window [ID_RELATIVE*ENGINE_SEQ_WIDTH, +ENGINE_SEQ_WIDTH).
- Throttles outstanding reads with a credit counter, counts responses, and reports completion.
- Sits between the lane control logic and the memory request arbiter.

Parameters:
NUM_ENGINES, 4, number of engines (offset windows) sequenced.
ENGINE_SEQ_WIDTH, 16, configuration words per engine.
TOTAL_WORDS, NUM_ENGINES*ENGINE_SEQ_WIDTH, derived; must be >= 1 and <= 65535.
WORD_BYTES, 4, byte stride between consecutive configuration words.
ADDR_WIDTH, 64, memory address width.
MAX_OUTSTANDING, 8, maximum issued-but-unanswered reads; must be >= 1.

Ports:
ap_clk  in  1  clock, all logic on rising edge.
ap_rst_n  in  1  reset, asynchronous assert, active-low.
start_in  in  1  single-cycle start pulse; honoured only in IDLE.
cfg_base_address_in  in  ADDR_WIDTH  base byte address; sampled on accepted start.
req_valid_out  out  1  read request valid.
req_ready_in  in  1  downstream accepts request when valid&ready.
req_address_out  out  ADDR_WIDTH  base + offset*WORD_BYTES.
req_offset_out  out  16  flat word offset, 0..TOTAL_WORDS-1.
resp_valid_in  in  1  one configuration-word response returned this cycle.
busy_out  out  1  high from the cycle after an accepted start through the cycle done_out pulses.
done_out  out  1  one-cycle pulse when all TOTAL_WORDS responses have returned.
stray_resp_out  out  1  sticky flag; set by a response while IDLE or with zero outstanding. Cleared by reset or the next accepted start.

Behaviour:
- Reset (ap_rst_n low, takes effect immediately and asynchronously): state=IDLE, req_valid_out=0, req_address_out=0, req_offset_out=0, busy_out=0, done_out=0, stray_resp_out=0, all counters=0. Release is used synchronously; the first sequential update occurs at the first edge with ap_rst_n high.
- States:
  - IDLE: start_in=1 latches the base, clears issue_cnt, resp_cnt, outstanding and stray_resp_out, and moves to ISSUE. busy_out=1 from the next cycle.
  - ISSUE: req_valid_out=1 whenever outstanding < MAX_OUTSTANDING. Offset=issue_cnt; address=base+issue_cnt*WORD_BYTES (multiply zero-extended to ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH). On handshake, issue_cnt++ and outstanding++. After the handshake with issue_cnt==TOTAL_WORDS-1, move to DRAIN.
  - DRAIN: req_valid_out=0; wait until resp_cnt reaches TOTAL_WORDS.
  - DONE: done_out=1 for exactly one cycle, busy_out=1 in that cycle, then IDLE. If the final response arrives while still in ISSUE (not possible with legal traffic), go directly to DONE after the last handshake.
- Latency: accepted start at cycle T gives req_valid_out=1 at T+1. Last response at cycle R gives done_out=1 at R+1.
- Handshake rules:
  - Once asserted, req_valid_out stays high until accepted.
  - req_address_out and req_offset_out are held stable while valid&!ready.
  - Credit is checked only before asserting valid, never to drop it.
- Responses:
  - resp_valid_in with outstanding>0 decrements outstanding and increments resp_cnt.
  - Request handshake and response in the same cycle leave outstanding unchanged; both counters still advance.
  - Credit boundary: at outstanding==MAX_OUTSTANDING valid stays low. A response in that cycle lets valid rise on the next cycle, not the same cycle.
  - A response when outstanding==0 (including IDLE) is ignored for counting and sets stray_resp_out.
- start_in outside IDLE is ignored; no restart and no counter change.
- Counter widths: issue_cnt and resp_cnt are 16 bits; outstanding is clog2(MAX_OUTSTANDING+1) bits and never over- or underflows.

Test Plan:
- Basic run, NUM_ENGINES=2, ENGINE_SEQ_WIDTH=16, base=0x1000, ready always 1, responses 3 cycles after each request -> offsets 0..31 issued, addresses 0x1000..0x107C. Exactly 32 handshakes, one done_out pulse 1 cycle after the 32nd response, busy_out drops the cycle after.
- Credit limit, MAX_OUTSTANDING=8, responses withheld -> exactly 8 requests (offsets 0..7) then req_valid_out=0. A single response re-enables valid next cycle with offset 8.
- Backpressure: req_ready_in low for 5 cycles while offset=3 is presented -> valid held, offset stays 3 and address stays base+12 through the stall. No skipped or duplicated offsets.
- Simultaneous: handshake and response in the same cycle at outstanding=4 -> outstanding stays 4, issue_cnt and resp_cnt both increment.
- Stray/ignored start: resp_valid_in in IDLE -> stray_resp_out=1, no request. start_in pulsed mid-ISSUE -> ignored, total handshakes remain 32. The next start from IDLE clears stray_resp_out.
- Reset mid-run: ap_rst_n low after 10 handshakes -> outputs 0 immediately, without waiting for a clock edge. After release and a new start, offsets restart at 0.
